instr_mem_loader: RTL and testbench

//  Boot-time writer for the instruction memory: accepts a byte stream (valid/ready),

---
 rtl/instr_mem_loader_pkg.sv | 21 ++
 rtl/instr_mem_loader_byte_packer.sv | 46 ++++
 rtl/instr_mem_loader.sv | 136 +++++++++++++
 tb/tb_instr_mem_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes per instruction word
//   WORD_SHIFT     : byte-address to word-index shift (instr_mem indexes addr[31:2])
//   BYTE_IDX_W     : width of the byte-within-word index
package instr_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_SHIFT     = 2;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word packer used for both the length header and the data words.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clear_i : discard any partial word and restart at byte 0
//   shift_i : accept byte_i this cycle
//   byte_i  : stream byte
//   word_o  : assembled word including the byte being accepted this cycle
//   full_o  : the byte accepted this cycle completes the word
module byte_packer
    import instr_mem_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          shift_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          full_o
);

    logic [BYTE_IDX_W-1:0]        idx_q;
    logic [8*BYTES_PER_WORD-1:0]  word_q;
    logic [8*BYTES_PER_WORD-1:0]  word_d;

    // Merge the incoming byte so the consumer sees the complete word on the 4th byte.
    always_comb begin
        word_d = word_q;
        if (shift_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
        end
    end

    assign word_o = word_d;
    assign full_o = shift_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (shift_i) begin
            word_q <= word_d;
            idx_q  <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time loader: parses a 4-byte LE word count, packs LE data words and writes them to
// the instruction RAM at byte addresses 0,4,8,...; holds the core in reset while loading.
//   clk, reset             : clock, synchronous active-high reset
//   start                  : pulse to begin a load (honoured in IDLE/DONE/ERR)
//   byte_in/valid/ready    : byte stream handshake
//   wr_en/wr_addr/wr_data  : instruction RAM write port (one cycle per word)
//   busy, cpu_hold         : load in progress
//   done, err              : sticky completion / oversize-header flags
//   words_written          : words written in the current or last load
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-1:0] words_written
);

    localparam int unsigned WordBits = 8 * BYTES_PER_WORD;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] idx_inc;
    logic [ADDR_WIDTH-1:0] words_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_en_q;
    logic                  done_q;
    logic                  err_q;

    logic                  start_ok;
    logic                  accept;
    logic                  pk_full;
    logic [WordBits-1:0]   pk_word;

    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign byte_ready = (state_q == HDR) || (state_q == DATA);
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE);
    assign cpu_hold   = busy;
    assign idx_inc    = idx_q + ADDR_WIDTH'(1);

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;

    // One packer serves the header and the data words; a new load drops any partial word.
    byte_packer u_packer (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (start_ok),
        .shift_i (accept),
        .byte_i  (byte_in),
        .word_o  (pk_word),
        .full_o  (pk_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_ok) begin
                        state_q <= HDR;
                        idx_q   <= '0;
                        words_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                HDR: begin
                    if (pk_full) begin
                        count_q <= ADDR_WIDTH'(pk_word);
                        if (pk_word == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (pk_word > WordBits'(MEM_SIZE)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (pk_full) begin
                        state_q   <= WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q << WORD_SHIFT;
                        wr_data_q <= DATA_WIDTH'(pk_word);
                    end
                end
                WRITE: begin
                    idx_q   <= idx_inc;
                    words_q <= words_q + ADDR_WIDTH'(1);
                    if (idx_inc == count_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected writes come from the image held in
// the bench (word i at address 4*i), checked against writes captured from the RAM port.
module tb_instr_mem_loader;

    localparam int unsigned MS = 512;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        start      = 1'b0;
    logic [7:0]  byte_in    = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;
    logic [31:0] words_written;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] img[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          viol    = 0;
    logic        prev_wr = 1'b0;

    instr_mem_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_SIZE   (MS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cpu_hold      (cpu_hold),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Capture every RAM write; a write must be single-cycle, aligned, and never overlap ready.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            if (byte_ready !== 1'b0 || prev_wr === 1'b1 || wr_addr[1:0] !== 2'b00) viol++;
        end
        prev_wr = wr_en;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int n;
        if (gaps) repeat ($urandom_range(3, 0)) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        acc        = 1'b0;
        n          = 0;
        while (!acc && n < 40) begin
            acc = (byte_ready === 1'b1);
            @(negedge clk);
            n++;
        end
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte: byte %h not accepted, byte_ready=%b, required 1", b,
                     byte_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, limit);
        end
        @(negedge clk);
    endtask

    task automatic clear_capture();
        got_addr.delete();
        got_data.delete();
        viol = 0;
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic run_load(input logic [31:0] hdr, input bit gaps);
        clear_capture();
        pulse_start();
        send_word(hdr, gaps);
        if (hdr != 0 && hdr <= MS) foreach (img[i]) send_word(img[i], gaps);
        wait_idle(50);
    endtask

    task automatic test_reset();
        logic [31:0] obs[9];
        string       nm[9];
        repeat (2) @(negedge clk);
        obs = '{32'(byte_ready), 32'(wr_en), wr_addr, wr_data, 32'(busy), 32'(done),
                32'(err), 32'(cpu_hold), words_written};
        nm  = '{"byte_ready", "wr_en", "wr_addr", "wr_data", "busy", "done", "err",
                "cpu_hold", "words_written"};
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (obs[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_%s: got %h, required 0", nm[i], obs[i]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        img = '{32'h0000_0013, 32'h0010_0093};
        clear_capture();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(img[0], 1'b0);
        tests_run++;
        if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 32'h13 || byte_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_first_write: wr_en=%b addr=%h data=%h ready=%b, required 1 0 13 0",
                     wr_en, wr_addr, wr_data, byte_ready);
        end
        send_word(img[1], 1'b0);
        wait_idle(50);
        tests_run++;
        if (got_addr.size() != 2) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d writes, required 2", got_addr.size());
        end else begin
            tests_run++;
            if (got_addr[1] !== 32'h4 || got_data[1] !== 32'h0010_0093) begin
                tests_failed++;
                $display("FAIL basic_second_write: addr=%h data=%h, required 4 00100093",
                         got_addr[1], got_data[1]);
            end
        end
        tests_run++;
        if (done !== 1'b1 || words_written !== 32'd2 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_status: done=%b words=%0d hold=%b err=%b, required 1 2 0 0",
                     done, words_written, cpu_hold, err);
        end
        tests_run++;
        if (viol != 0) begin
            tests_failed++;
            $display("FAIL basic_write_shape: %0d bad write cycles, required 0", viol);
        end
    endtask

    task automatic test_zero_header();
        clear_capture();
        pulse_start();
        send_word(32'd0, 1'b0);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: done=%b busy=%b ready=%b, required 1 0 0",
                     done, busy, byte_ready);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (got_addr.size() != 0 || words_written !== 32'd0) begin
            tests_failed++;
            $display("FAIL zero_writes: writes=%0d words=%0d, required 0 0",
                     got_addr.size(), words_written);
        end
    endtask

    task automatic test_oversize();
        clear_capture();
        pulse_start();
        send_word(32'h0000_0201, 1'b0);
        tests_run++;
        if (err !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL oversize_flags: err=%b done=%b ready=%b busy=%b, required 1 0 0 0",
                     err, done, byte_ready, busy);
        end
        byte_valid = 1'b1;
        repeat (5) begin
            byte_in = 8'($urandom);
            @(negedge clk);
            tests_run++;
            if (byte_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL oversize_ready: byte_ready=%b, required 0", byte_ready);
            end
        end
        byte_valid = 1'b0;
        tests_run++;
        if (got_addr.size() != 0 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL oversize_writes: writes=%0d err=%b, required 0 1",
                     got_addr.size(), err);
        end
    endtask

    task automatic test_full_random();
        fill_img(MS);
        run_load(MS, 1'b1);
        tests_run++;
        if (got_addr.size() != MS) begin
            tests_failed++;
            $display("FAIL full_count: got %0d writes, required %0d", got_addr.size(), MS);
        end else begin
            for (int i = 0; i < MS; i++) begin
                tests_run++;
                if (got_addr[i] !== 32'(4 * i) || got_data[i] !== img[i]) begin
                    tests_failed++;
                    $display("FAIL full_word%0d: addr=%h data=%h, required %h %h", i,
                             got_addr[i], got_data[i], 32'(4 * i), img[i]);
                end
            end
            tests_run++;
            if (got_addr[MS-1] !== 32'h7FC) begin
                tests_failed++;
                $display("FAIL full_last_addr: got %h, required 7fc", got_addr[MS-1]);
            end
        end
        tests_run++;
        if (done !== 1'b1 || err !== 1'b0 || words_written !== 32'(MS) || viol != 0) begin
            tests_failed++;
            $display("FAIL full_status: done=%b err=%b words=%0d viol=%0d, required 1 0 %0d 0",
                     done, err, words_written, viol, MS);
        end
    endtask

    task automatic test_reset_mid_load();
        fill_img(5);
        clear_capture();
        pulse_start();
        send_word(32'd5, 1'b0);
        for (int i = 0; i < 3; i++) send_word(img[i], 1'b0);
        send_byte(img[3][7:0], 1'b0);
        send_byte(img[3][15:8], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            byte_ready !== 1'b0 || cpu_hold !== 1'b0 || words_written !== 32'd0 ||
            wr_addr !== 32'd0 || wr_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: en=%b busy=%b done=%b err=%b rdy=%b hold=%b words=%0d addr=%h data=%h, required all 0",
                     wr_en, busy, done, err, byte_ready, cpu_hold, words_written, wr_addr,
                     wr_data);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (got_addr.size() != 3) begin
            tests_failed++;
            $display("FAIL midreset_writes: got %0d writes, required 3", got_addr.size());
        end
        fill_img(4);
        run_load(32'd4, 1'b1);
        tests_run++;
        if (got_addr.size() != 4) begin
            tests_failed++;
            $display("FAIL midreset_reload_count: got %0d writes, required 4", got_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (got_addr[i] !== 32'(4 * i) || got_data[i] !== img[i]) begin
                    tests_failed++;
                    $display("FAIL midreset_reload_word%0d: addr=%h data=%h, required %h %h",
                             i, got_addr[i], got_data[i], 32'(4 * i), img[i]);
                end
            end
        end
    endtask

    task automatic test_start_handling();
        fill_img(3);
        clear_capture();
        pulse_start();
        send_word(32'd3, 1'b0);
        send_byte(img[0][7:0], 1'b0);
        send_byte(img[0][15:8], 1'b0);
        pulse_start();
        tests_run++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_ignored_busy: busy=%b ready=%b, required 1 1", busy, byte_ready);
        end
        send_byte(img[0][23:16], 1'b0);
        send_byte(img[0][31:24], 1'b0);
        send_word(img[1], 1'b1);
        send_word(img[2], 1'b1);
        wait_idle(50);
        tests_run++;
        if (got_addr.size() != 3) begin
            tests_failed++;
            $display("FAIL start_ignored_count: got %0d writes, required 3", got_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (got_addr[i] !== 32'(4 * i) || got_data[i] !== img[i]) begin
                    tests_failed++;
                    $display("FAIL start_ignored_word%0d: addr=%h data=%h, required %h %h",
                             i, got_addr[i], got_data[i], 32'(4 * i), img[i]);
                end
            end
        end
        // Restart from DONE clears the sticky status and reloads.
        fill_img(2);
        clear_capture();
        pulse_start();
        tests_run++;
        if (done !== 1'b0 || words_written !== 32'd0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_clear: done=%b words=%0d busy=%b hold=%b, required 0 0 1 1",
                     done, words_written, busy, cpu_hold);
        end
        send_word(32'd2, 1'b0);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        wait_idle(50);
        tests_run++;
        if (got_addr.size() != 2 || done !== 1'b1 || words_written !== 32'd2) begin
            tests_failed++;
            $display("FAIL restart_status: writes=%0d done=%b words=%0d, required 2 1 2",
                     got_addr.size(), done, words_written);
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (got_addr[i] !== 32'(4 * i) || got_data[i] !== img[i]) begin
                    tests_failed++;
                    $display("FAIL restart_word%0d: addr=%h data=%h, required %h %h",
                             i, got_addr[i], got_data[i], 32'(4 * i), img[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_header();
        test_oversize();
        test_full_random();
        test_reset_mid_load();
        test_start_handling();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
